// File: rtl/door_pkg.sv
// Shared constants for the door input conditioner: channel indices and default debounce depth.
// The optional glitch counter is enabled by DOOR_COND_GLITCH_CNT_EN (see door_input_conditioner).
package door_pkg;

    localparam int NUM_CH          = 4;
    localparam int CH_SEN          = 0;
    localparam int CH_SE           = 1;
    localparam int CH_LA           = 2;
    localparam int CH_LC           = 3;
    localparam int DEB_CYCLES_DEF  = 16;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/door_debounce_ch.sv
// One conditioned input: multi-flop synchroniser, debounce counter and stable level,
// plus strobes for an imminent stable-level change and for an aborted bounce.
module door_debounce_ch #(
    parameter int DEB_CYCLES  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic raw_i,
    output logic stable_o,
    output logic upd_o,
    output logic abort_o
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   sync_w;

    assign sync_w = sync_q[SYNC_STAGES-1];

    // upd_o fires on the enabled edge that will flip the stable level.
    assign upd_o   = ena && (sync_w != stable_q) && (cnt_q == CNT_MAX);
    assign abort_o = ena && (sync_w == stable_q) && (cnt_q != '0);

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (ena) begin
            if (sync_w == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                stable_d = sync_w;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/door_input_conditioner.sv
// Conditions the Sen/SE/LA/LC door inputs and derives sen_rise and a sticky limit fault.
// Define DOOR_COND_GLITCH_CNT_EN to build the saturating aborted-bounce counter.
module door_input_conditioner
    import door_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [NUM_CH-1:0] raw_in,
    input  logic              fault_clr,
    output logic [NUM_CH-1:0] clean_out,
    output logic              sen_rise,
    output logic              limit_fault,
    output logic [7:0]        glitch_cnt
);

    logic [NUM_CH-1:0] stable_w, upd_w, abort_w;
    logic              sen_rise_q, sen_rise_d;
    logic              fault_q, fault_d;
    logic              both_limits_w;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        door_debounce_ch #(
            .DEB_CYCLES (DEB_CYCLES),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .ena     (ena),
            .raw_i   (raw_in[g]),
            .stable_o(stable_w[g]),
            .upd_o   (upd_w[g]),
            .abort_o (abort_w[g])
        );
    end

    assign both_limits_w = stable_w[CH_LA] && stable_w[CH_LC];

    // Raising sen_rise on the same edge that lifts the stable level keeps them aligned.
    always_comb begin
        sen_rise_d = upd_w[CH_SEN] && !stable_w[CH_SEN];
        fault_d    = fault_q;
        if (both_limits_w) begin
            fault_d = 1'b1;
        end else if (ena && fault_clr) begin
            fault_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sen_rise_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            sen_rise_q <= sen_rise_d;
            fault_q    <= fault_d;
        end
    end

`ifdef DOOR_COND_GLITCH_CNT_EN
    logic [7:0] glitch_q, glitch_d;

    always_comb begin
        glitch_d = glitch_q;
        if ((|abort_w) && (glitch_q != 8'hFF)) begin
            glitch_d = glitch_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_q <= 8'd0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt = glitch_q;
`else
    logic unused_abort;
    assign unused_abort = ^abort_w;
    assign glitch_cnt   = 8'd0;
`endif

    assign clean_out   = stable_w;
    assign sen_rise    = sen_rise_q;
    assign limit_fault = fault_q;

endmodule

// File: tb/tb_door_input_conditioner.sv
// Directed bench for door_input_conditioner with DEB_CYCLES=4, SYNC_STAGES=2.
// Glitch-count expectations follow DOOR_COND_GLITCH_CNT_EN when the bench is built with it.
module tb_door_input_conditioner;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [3:0] raw_in;
    logic       fault_clr;
    logic [3:0] clean_out;
    logic       sen_rise;
    logic       limit_fault;
    logic [7:0] glitch_cnt;

    int n_tests;
    int n_fail;

    door_input_conditioner #(
        .DEB_CYCLES (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .raw_in     (raw_in),
        .fault_clr  (fault_clr),
        .clean_out  (clean_out),
        .sen_rise   (sen_rise),
        .limit_fault(limit_fault),
        .glitch_cnt (glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] glitch_exp(input int n);
`ifdef DOOR_COND_GLITCH_CNT_EN
        return (n > 255) ? 8'd255 : 8'(n);
`else
        return (n < 0) ? 8'd1 : 8'd0;
`endif
    endfunction

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        ena       = 1'b1;
        raw_in    = 4'b0000;
        fault_clr = 1'b0;
        step(2);
        check("reset_clean", 32'(clean_out), 32'h0);
        check("reset_rise", 32'(sen_rise), 32'h0);
        check("reset_fault", 32'(limit_fault), 32'h0);
        check("reset_glitch", 32'(glitch_cnt), 32'h0);
        rst_n = 1'b1;
        step(1);

        // Sensor rise: clean at edge 6, pulse for that cycle only.
        raw_in[0] = 1'b1;
        step(5);
        check("sen_edge5_clean", 32'(clean_out[0]), 32'h0);
        check("sen_edge5_rise", 32'(sen_rise), 32'h0);
        step(1);
        check("sen_edge6_clean", 32'(clean_out[0]), 32'h1);
        check("sen_edge6_rise", 32'(sen_rise), 32'h1);
        step(1);
        check("sen_rise_one_cycle", 32'(sen_rise), 32'h0);
        check("sen_clean_held", 32'(clean_out[0]), 32'h1);

        // LA pulse of 3 sampled cycles is rejected.
        raw_in[2] = 1'b1;
        step(3);
        raw_in[2] = 1'b0;
        step(6);
        check("la_pulse_rejected", 32'(clean_out[2]), 32'h0);
        check("la_pulse_glitch", 32'(glitch_cnt), 32'(glitch_exp(1)));

        // LC with ena dropped after two counts.
        raw_in[3] = 1'b1;
        step(4);
        ena = 1'b0;
        step(5);
        check("lc_frozen", 32'(clean_out[3]), 32'h0);
        ena = 1'b1;
        step(1);
        check("lc_resume_edge1", 32'(clean_out[3]), 32'h0);
        step(1);
        check("lc_resume_edge2", 32'(clean_out[3]), 32'h1);
        check("lc_clean_vec", 32'(clean_out), 32'h9);

        // Limit fault set, held against clear, then cleared.
        raw_in[2] = 1'b1;
        step(6);
        check("fault_both_high", 32'(clean_out), 32'hD);
        check("fault_not_yet", 32'(limit_fault), 32'h0);
        step(1);
        check("fault_set", 32'(limit_fault), 32'h1);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        check("fault_clr_blocked", 32'(limit_fault), 32'h1);
        raw_in[3] = 1'b0;
        step(5);
        check("lc_drop_edge5", 32'(clean_out[3]), 32'h1);
        step(1);
        check("lc_drop_edge6", 32'(clean_out[3]), 32'h0);
        step(2);
        check("fault_sticky", 32'(limit_fault), 32'h1);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        check("fault_cleared", 32'(limit_fault), 32'h0);

        // Reset mid-count with all channels stable high.
        raw_in = 4'b1111;
        step(6);
        check("all_high", 32'(clean_out), 32'hF);
        step(1);
        check("all_high_fault", 32'(limit_fault), 32'h1);
        raw_in[0] = 1'b0;
        step(3);
        rst_n = 1'b0;
        #1;
        check("async_rst_clean", 32'(clean_out), 32'h0);
        check("async_rst_fault", 32'(limit_fault), 32'h0);
        check("async_rst_rise", 32'(sen_rise), 32'h0);
        check("async_rst_glitch", 32'(glitch_cnt), 32'h0);
        raw_in = 4'b1111;
        step(1);
        rst_n = 1'b1;
        step(5);
        check("post_rst_edge5", 32'(clean_out), 32'h0);
        step(1);
        check("post_rst_edge6", 32'(clean_out), 32'hF);
        check("post_rst_rise", 32'(sen_rise), 32'h1);
        step(1);
        check("post_rst_fault", 32'(limit_fault), 32'h1);

        // Single-cycle low bounces on SE drive the glitch counter to saturation.
        for (int b = 0; b < 300; b++) begin
            raw_in[1] = 1'b0;
            step(1);
            raw_in[1] = 1'b1;
            step(3);
            if (b == 9) begin
                check("glitch_after_10", 32'(glitch_cnt), 32'(glitch_exp(10)));
            end
        end
        check("glitch_saturated", 32'(glitch_cnt), 32'(glitch_exp(300)));
        check("bounce_clean_held", 32'(clean_out), 32'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
